// File: rtl/branch_pkg.sv
// Shared branch definitions: funct3 condition codes and the resolved-branch
// result record used by execute, decode and the trap unit.
package branch_pkg;

    localparam int MAX_XLEN = 64;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // new_pc is sized for the widest datapath; narrower units zero-extend.
    typedef struct packed {
        logic                taken;
        logic [MAX_XLEN-1:0] new_pc;
        logic                mispredict;
        logic                error_illegal;
        logic                error_misaligned;
    } branch_result_t;

endpackage

// File: rtl/branch_compare.sv
// Branch condition evaluator: decides taken/illegal from funct3 and the two
// register operands. Purely combinational.
module branch_compare
    import branch_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] lhs,
    input  logic [XLEN-1:0] rhs,
    output logic            taken,
    output logic            illegal
);

    logic [XLEN-1:0] lhs_biased;
    logic [XLEN-1:0] rhs_biased;
    logic            equal;
    logic            less_unsigned;
    logic            less_signed;

    // Flipping the sign bits turns a signed compare into an unsigned one.
    assign lhs_biased    = {~lhs[XLEN-1], lhs[XLEN-2:0]};
    assign rhs_biased    = {~rhs[XLEN-1], rhs[XLEN-2:0]};
    assign equal         = (lhs == rhs);
    assign less_unsigned = (lhs < rhs);
    assign less_signed   = (lhs_biased < rhs_biased);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            F3_BEQ:  taken = equal;
            F3_BNE:  taken = !equal;
            F3_BLT:  taken = less_signed;
            F3_BGE:  taken = !less_signed;
            F3_BLTU: taken = less_unsigned;
            F3_BGEU: taken = !less_unsigned;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Registered branch-resolution unit: computes target/fallthrough, flags bad
// encodings and alignment, holds one result behind ready/valid, counts events.
module branch_unit
    import branch_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int IALIGN      = 32,
    parameter int COUNT_WIDTH = 32
) (
    input  logic                   clock,
    input  logic                   clear,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [XLEN-1:0]        pc,
    input  logic [XLEN-1:0]        lhs,
    input  logic [XLEN-1:0]        rhs,
    input  logic [XLEN-1:0]        b_immediate,
    input  logic [2:0]             funct3,
    input  logic                   compressed,
    input  logic                   predicted_taken,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   taken,
    output logic [XLEN-1:0]        new_pc,
    output logic                   mispredict,
    output logic                   error_illegal,
    output logic                   error_misaligned,
    output logic [COUNT_WIDTH-1:0] resolved_count,
    output logic [COUNT_WIDTH-1:0] mispredict_count
);

    logic            cmp_taken;
    logic            cmp_illegal;
    logic            is_compressed;
    logic            misaligned;
    logic            accept;
    logic            handshake;
    logic [XLEN-1:0] target;
    logic [XLEN-1:0] fallthrough;
    branch_result_t  result_d;
    branch_result_t  result_q;

    branch_compare #(.XLEN(XLEN)) u_compare (
        .funct3  (funct3),
        .lhs     (lhs),
        .rhs     (rhs),
        .taken   (cmp_taken),
        .illegal (cmp_illegal)
    );

    // Without the C extension there are no 16-bit branches to step over.
    assign is_compressed = (IALIGN == 16) ? compressed : 1'b0;
    assign target        = pc + b_immediate;
    assign fallthrough   = pc + (is_compressed ? XLEN'(2) : XLEN'(4));
    assign misaligned    = cmp_taken &
                           ((IALIGN == 32) ? (target[1:0] != 2'b00) : target[0]);

    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready && !flush;
    assign handshake = out_valid && out_ready;

    // Illegal encodings report a clean zero result; a misaligned target is
    // still carried on new_pc so the trap unit can use it as mtval.
    always_comb begin
        result_d = '0;
        if (cmp_illegal) begin
            result_d.error_illegal = 1'b1;
        end else begin
            result_d.taken            = cmp_taken;
            result_d.error_misaligned = misaligned;
            result_d.new_pc           = MAX_XLEN'(cmp_taken ? target : fallthrough);
            result_d.mispredict       = !misaligned && (cmp_taken != predicted_taken);
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            out_valid        <= 1'b0;
            result_q         <= '0;
            resolved_count   <= '0;
            mispredict_count <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                result_q  <= result_d;
            end else if (flush || handshake) begin
                out_valid <= 1'b0;
            end

            // Counters see the result leaving, even when a flush hits the same cycle.
            if (handshake) begin
                if (resolved_count != '1) begin
                    resolved_count <= resolved_count + COUNT_WIDTH'(1);
                end
                if (result_q.mispredict && (mispredict_count != '1)) begin
                    mispredict_count <= mispredict_count + COUNT_WIDTH'(1);
                end
            end
        end
    end

    assign taken            = result_q.taken;
    assign new_pc           = result_q.new_pc[XLEN-1:0];
    assign mispredict       = result_q.mispredict;
    assign error_illegal    = result_q.error_illegal;
    assign error_misaligned = result_q.error_misaligned;

    generate
        if (XLEN < MAX_XLEN) begin : g_pc_pad
            logic unused_pc_pad;
            assign unused_pc_pad = ^result_q.new_pc[MAX_XLEN-1:XLEN];
        end
    endgenerate

endmodule

// File: tb/tb_branch_unit.sv
// Randomised bench for branch_unit: two instances (IALIGN 32 / 16, wide and
// 2-bit counters) share stimulus and are compared with a behavioural model.
module tb_branch_unit;

    logic        clock = 1'b0;
    logic        clear;
    logic        flush;
    logic        in_valid;
    logic [31:0] pc;
    logic [31:0] lhs;
    logic [31:0] rhs;
    logic [31:0] b_immediate;
    logic [2:0]  funct3;
    logic        compressed;
    logic        predicted_taken;
    logic        out_ready;

    logic        in_ready_a, out_valid_a, taken_a, mispredict_a, illegal_a, misaligned_a;
    logic [31:0] new_pc_a, resolved_a, mispredicts_a;
    logic        in_ready_b, out_valid_b, taken_b, mispredict_b, illegal_b, misaligned_b;
    logic [31:0] new_pc_b;
    logic [1:0]  resolved_b, mispredicts_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    branch_unit #(.XLEN(32), .IALIGN(32), .COUNT_WIDTH(32)) dut_a (
        .clock(clock), .clear(clear), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_a),
        .pc(pc), .lhs(lhs), .rhs(rhs), .b_immediate(b_immediate), .funct3(funct3),
        .compressed(compressed), .predicted_taken(predicted_taken), .out_valid(out_valid_a),
        .out_ready(out_ready), .taken(taken_a), .new_pc(new_pc_a), .mispredict(mispredict_a),
        .error_illegal(illegal_a), .error_misaligned(misaligned_a),
        .resolved_count(resolved_a), .mispredict_count(mispredicts_a)
    );

    branch_unit #(.XLEN(32), .IALIGN(16), .COUNT_WIDTH(2)) dut_b (
        .clock(clock), .clear(clear), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
        .pc(pc), .lhs(lhs), .rhs(rhs), .b_immediate(b_immediate), .funct3(funct3),
        .compressed(compressed), .predicted_taken(predicted_taken), .out_valid(out_valid_b),
        .out_ready(out_ready), .taken(taken_b), .new_pc(new_pc_b), .mispredict(mispredict_b),
        .error_illegal(illegal_b), .error_misaligned(misaligned_b),
        .resolved_count(resolved_b), .mispredict_count(mispredicts_b)
    );

    // Model state: one slot shared by both units, results and counts per unit.
    bit          exp_valid = 1'b0;
    bit          exp_taken[2];
    bit [31:0]   exp_pc[2];
    bit          exp_misp[2];
    bit          exp_ill[2];
    bit          exp_mis[2];
    longint      res_cnt[2];
    longint      misp_cnt[2];
    bit          last_clear;
    int          ialign_of[2] = '{32, 16};
    longint      cnt_max[2]   = '{64'hFFFF_FFFF, 64'd3};

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    function automatic void refResult(input int ialign, input bit [31:0] p, l, r, imm,
                                      input bit [2:0] f3, input bit comp, pred,
                                      output bit tk, output bit [31:0] npc,
                                      output bit misp, output bit ill, output bit mis);
        bit [31:0] tgt;
        bit [31:0] fall;
        tgt  = p + imm;
        fall = p + ((ialign == 16 && comp) ? 32'd2 : 32'd4);
        tk   = 1'b0;
        ill  = 1'b0;
        case (f3)
            3'd0:    tk = (l == r);
            3'd1:    tk = (l != r);
            3'd4:    tk = ($signed(l) <  $signed(r));
            3'd5:    tk = ($signed(l) >= $signed(r));
            3'd6:    tk = (l <  r);
            3'd7:    tk = (l >= r);
            default: ill = 1'b1;
        endcase
        mis  = tk && ((ialign == 32) ? (tgt % 4 != 0) : (tgt % 2 != 0));
        npc  = ill ? 32'd0 : (tk ? tgt : fall);
        misp = !ill && !mis && (tk != pred);
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return (v > m) ? m : v;
    endfunction

    task automatic checkDut(input string n, input int k, input logic ov, tk, input logic [31:0] npc,
                            input logic misp, ill, mis, input logic [31:0] rc, mc);
        checkOutput({n, ".out_valid"}, 64'(ov), 64'(exp_valid));
        checkOutput({n, ".resolved_count"}, 64'(rc), 64'(sat(res_cnt[k], cnt_max[k])));
        checkOutput({n, ".mispredict_count"}, 64'(mc), 64'(sat(misp_cnt[k], cnt_max[k])));
        if (exp_valid || last_clear) begin
            checkOutput({n, ".taken"}, 64'(tk), 64'(exp_taken[k]));
            checkOutput({n, ".new_pc"}, 64'(npc), 64'(exp_pc[k]));
            checkOutput({n, ".mispredict"}, 64'(misp), 64'(exp_misp[k]));
            checkOutput({n, ".error_illegal"}, 64'(ill), 64'(exp_ill[k]));
            checkOutput({n, ".error_misaligned"}, 64'(mis), 64'(exp_mis[k]));
        end
    endtask

    task automatic applyStimulus(input bit clr, fl, iv, input bit [31:0] p, l, r, imm,
                                 input bit [2:0] f3, input bit comp, pred, ordy);
        bit hs;
        bit acc;
        clear = clr; flush = fl; in_valid = iv; pc = p; lhs = l; rhs = r;
        b_immediate = imm; funct3 = f3; compressed = comp; predicted_taken = pred; out_ready = ordy;
        #1;
        checkOutput("a.in_ready", 64'(in_ready_a), 64'(!exp_valid || ordy));
        checkOutput("b.in_ready", 64'(in_ready_b), 64'(!exp_valid || ordy));
        last_clear = clr;
        if (clr) begin
            exp_valid = 1'b0;
            for (int k = 0; k < 2; k++) begin
                exp_taken[k] = 0; exp_pc[k] = 0; exp_misp[k] = 0; exp_ill[k] = 0; exp_mis[k] = 0;
                res_cnt[k] = 0; misp_cnt[k] = 0;
            end
        end else begin
            hs  = exp_valid && ordy;
            acc = iv && (!exp_valid || ordy) && !fl;
            for (int k = 0; k < 2; k++) begin
                if (hs) begin
                    res_cnt[k]++;
                    if (exp_misp[k]) misp_cnt[k]++;
                end
                if (acc)
                    refResult(ialign_of[k], p, l, r, imm, f3, comp, pred,
                              exp_taken[k], exp_pc[k], exp_misp[k], exp_ill[k], exp_mis[k]);
            end
            if (acc) exp_valid = 1'b1;
            else if (fl || hs) exp_valid = 1'b0;
        end
        @(posedge clock);
        #1;
        checkDut("a", 0, out_valid_a, taken_a, new_pc_a, mispredict_a, illegal_a, misaligned_a,
                 resolved_a, mispredicts_a);
        checkDut("b", 1, out_valid_b, taken_b, new_pc_b, mispredict_b, illegal_b, misaligned_b,
                 32'(resolved_b), 32'(mispredicts_b));
    endtask

    task automatic idle(input bit ordy);
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0, 3'd0, 0, 0, ordy);
    endtask

    initial begin
        bit [31:0] r_rhs;
        clear = 1'b1; flush = 0; in_valid = 0; pc = 0; lhs = 0; rhs = 0;
        b_immediate = 0; funct3 = 0; compressed = 0; predicted_taken = 0; out_ready = 0;
        @(posedge clock);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 0, 3'd0, 0, 0, 0);
        idle(0);

        // Back-to-back BEQ then BLTU, then drain.
        applyStimulus(0, 0, 1, 32'h100, 32'd5, 32'd5, 32'h20, 3'd0, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h100, 32'd1, 32'hFFFF_FFFF, 32'h20, 3'd6, 0, 1, 1);
        idle(1);

        // Signed compares, compressed fallthrough, illegal, misaligned target.
        applyStimulus(0, 0, 1, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'd4, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h100, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'd5, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h200, 32'hFFFF_FFFF, 32'd1, 32'h40, 3'd5, 1, 0, 1);
        applyStimulus(0, 0, 1, 32'h100, 32'd7, 32'd7, 32'h40, 3'd3, 0, 1, 1);
        applyStimulus(0, 0, 1, 32'h100, 32'd7, 32'd7, 32'h6, 3'd0, 0, 0, 1);
        idle(1);

        // Back-pressure: hold a result for three cycles while offering more.
        applyStimulus(0, 0, 1, 32'h300, 32'd3, 32'd9, 32'h10, 3'd1, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            applyStimulus(0, 0, 1, 32'h400 + i, 32'd1, 32'd2, 32'h8, 3'd0, 0, 1, 0);
        idle(1);

        // Flush on an incoming beat, then flush of a held result.
        applyStimulus(0, 1, 1, 32'h500, 32'd1, 32'd1, 32'h8, 3'd0, 0, 0, 1);
        applyStimulus(0, 0, 1, 32'h500, 32'd1, 32'd1, 32'h8, 3'd0, 0, 0, 0);
        applyStimulus(0, 1, 0, 32'h0, 32'd0, 32'd0, 32'h0, 3'd0, 0, 0, 0);
        idle(1);

        // Clear while a result is held and the counters are non-zero.
        applyStimulus(0, 0, 1, 32'h600, 32'd2, 32'd1, 32'h8, 3'd7, 0, 0, 0);
        applyStimulus(1, 0, 1, 32'h600, 32'd2, 32'd1, 32'h8, 3'd7, 0, 0, 1);

        for (int i = 0; i < 400; i++) begin
            r_rhs = $urandom;
            applyStimulus(($urandom % 60) == 0, ($urandom % 15) == 0, ($urandom % 4) != 0,
                          $urandom, ($urandom % 3 == 0) ? r_rhs : $urandom, r_rhs,
                          $urandom_range(0, 255) - 32'd128, 3'($urandom), 1'($urandom),
                          1'($urandom), ($urandom % 4) != 0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
